// File: rtl/mips_pkg.sv
// Shared definitions for the fetch stage and the next-PC block.
package mips_pkg;

   // Word address of an instruction: byte address bits [31:2]
   typedef logic [29:0] word_addr_t;

   // Byte address 0x0000_3000 expressed as a word address
   localparam word_addr_t RESET_PC_DEFAULT = 30'h0000_0C00;

   // Fetch sequencing; code 2'd3 is unused and recovers to S_REQ
   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/pc_fetch_if.sv
// Instruction-memory request/response bundle between fetch and memory.
interface pc_fetch_if;
   import mips_pkg::*;

   logic        imem_req;
   word_addr_t  imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   // Fetch side drives the request, memory answers with ready/rvalid/rdata
   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rvalid,
      output imem_rdata
   );

endinterface

// File: rtl/pc_fetch.sv
// Fetch stage: holds the architectural PC, issues one memory request per PC,
// buffers the returned word for decode and advances PC on decode accept.
module pc_fetch
   import mips_pkg::*;
#(
   parameter word_addr_t RESET_PC = RESET_PC_DEFAULT,
   parameter int         CNT_W    = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  word_addr_t        nextpc,
   output word_addr_t        pc,
   pc_fetch_if.master        imem,
   output logic [31:0]       instr,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [CNT_W-1:0]  icount
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   fetch_state_t state;

   // Request is held while in S_REQ; suppressed during reset so the memory
   // never sees a request before the first post-reset cycle.
   assign imem.imem_req  = (state == S_REQ) && !rst;
   assign imem.imem_addr = pc;

   // Fetch sequencer with PC register, instruction buffer and retire counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_REQ;
         pc          <= RESET_PC;
         instr       <= 32'h0;
         instr_valid <= 1'b0;
         icount      <= '0;
      end else begin
         case (state)
            S_REQ: begin
               // Any rvalid seen here belongs to nobody and is dropped
               if (imem.imem_ready) begin
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (imem.imem_rvalid) begin
                  instr       <= imem.imem_rdata;
                  instr_valid <= 1'b1;
                  state       <= S_HOLD;
               end
            end
            S_HOLD: begin
               // nextpc is only meaningful on the consume edge
               if (instr_ready) begin
                  pc          <= nextpc;
                  instr_valid <= 1'b0;
                  icount      <= icount + CNT_ONE;
                  state       <= S_REQ;
               end
            end
            default: begin
               state       <= S_REQ;
               instr_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/pc_fetch.md
Name: pc_fetch

Overview:
- Fetch stage directly upstream of the next-PC logic.
- Holds the architectural PC as a word address [31:2] and drives it to the next-PC block, which returns nextpc.
- Issues one instruction-memory request per PC using a req/ready + rvalid handshake, and buffers the returned word for decode.
- Advances PC <= nextpc only when decode accepts the instruction, i.e. on instr_valid && instr_ready.

Parameters:
- RESET_PC, 30'h0000_0C00, word address loaded on reset (byte address 0x0000_3000).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- nextpc  in  30  [31:2] next PC from the next-PC block
- pc  out  30  [31:2] current PC, to the next-PC block and decode
- imem_req  out  1  fetch request valid
- imem_addr  out  30  [31:2] fetch word address (equals pc)
- imem_ready  in  1  memory accepts the request this cycle
- imem_rvalid  in  1  read data valid
- imem_rdata  in  32  read data
- instr  out  32  buffered instruction
- instr_valid  out  1  instr is valid for decode
- instr_ready  in  1  decode consumes instr this cycle
- icount  out  CNT_W  count of instructions handed to decode

Behaviour:
- Reset (sync, rst=1 at posedge):
  - pc = RESET_PC, state = S_REQ, instr = 0, instr_valid = 0, icount = 0.
  - While rst is high, imem_req is forced to 0.
- State encoding: S_REQ=2'd0, S_WAIT=2'd1, S_HOLD=2'd2. Code 2'd3 is illegal and recovers to S_REQ on the next edge.
- S_REQ:
  - Outputs: imem_req = 1, imem_addr = pc.
  - If imem_ready, go to S_WAIT; otherwise stay, holding req and addr stable.
  - imem_rvalid is ignored here (stale data is dropped).
- S_WAIT:
  - Outputs: imem_req = 0.
  - On imem_rvalid: instr <= imem_rdata, instr_valid <= 1, go to S_HOLD. Otherwise stay; there is no timeout.
- S_HOLD:
  - Outputs: instr_valid = 1; instr is stable.
  - On instr_ready: pc <= nextpc, instr_valid <= 0, icount <= icount + 1 (wraps mod 2^CNT_W), go to S_REQ.
  - imem_rvalid is ignored here.
- Latency:
  - With memory returning rvalid one cycle after acceptance and decode always ready, each instruction takes 3 cycles (REQ, WAIT, HOLD).
  - The first imem_req occurs in the cycle after rst deasserts.
- pc changes only on the S_HOLD consume edge or on reset. imem_addr is purely combinational from pc.
- nextpc is sampled only on the consume edge. Its value in other cycles is don't-care.
- Wrap-around: nextpc = 30'h3FFF_FFFF+1 style values are produced by the next-PC block. This block loads them verbatim, with no alignment or range checks.
- Simultaneous imem_ready and imem_rvalid in S_REQ: accept the request; the rvalid is dropped.
- Reset mid-operation (S_WAIT or S_HOLD):
  - The outstanding fetch is abandoned and instr_valid drops on the reset edge.
  - The memory shares rst, so no response for the abandoned request arrives after reset.

Decomposition:
- Shared package mips_pkg holds:
  - the fetch state encoding (S_REQ, S_WAIT, S_HOLD),
  - the RESET_PC default constant,
  - the 30-bit word-address type used by the next-PC block and this block.
- No sub-module. The PC register, FSM, instruction buffer and counter stay in pc_fetch.

Test Plan:
- Reset release, memory ready=1, rvalid 1 cycle later, instr_ready=1, nextpc=pc+1 → imem_addr sequence 0xC00, 0xC01, 0xC02; instr_valid pulses every 3rd cycle; icount = 3 after 9 cycles.
- Hold imem_ready=0 for 4 cycles in S_REQ → imem_req and imem_addr stay constant (0xC00); pc unchanged.
- instr_ready=0 for 5 cycles in S_HOLD, then rdata=32'h2401_0005 → instr stays 32'h2401_0005 with instr_valid=1 throughout; pc advances only on the ready edge.
- Jump: nextpc=30'h0000_0D40 at the consume edge → next imem_addr = 0xD40; icount increments by 1.
- Spurious imem_rvalid=1 with rdata=32'hDEAD_BEEF in S_REQ and S_HOLD → instr unchanged, no state change.
- Assert rst in S_WAIT with pc=0xD40 → next cycle pc=0xC00, instr_valid=0, icount=0, imem_req=0 while rst is high; imem_req=1 in the first cycle after release.
